// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: shifts qualified bits, masks-compares the last LEN against PATTERN.
// Optional saturating match counter built when SEQDET_COUNT_EN is defined.
module seq_pattern_detector #(
  parameter int unsigned      LEN     = 4,
  parameter logic [LEN-1:0]   PATTERN = 4'b1100,
  parameter logic [LEN-1:0]   MASK    = 4'b1110,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap,
  output logic             match,
  output logic             filled,
`ifdef SEQDET_COUNT_EN
  output logic [CNT_W-1:0] match_count,
`endif
  output logic [LEN-1:0]   history
);

  localparam int unsigned   FW   = $clog2(LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(LEN);

  logic [LEN-1:0] hist_q, hist_d, next_hist;
  logic [FW-1:0]  fill_q, fill_d, next_fill;
  logic           match_q, match_d;
  logic           hit;

  always_comb begin
    next_hist = {hist_q[LEN-2:0], in_bit};
    next_fill = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    hit       = in_valid && !clear && (next_fill == FULL)
                && (((next_hist ^ PATTERN) & MASK) == '0);

    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d  = next_hist;
      match_d = hit;
      // Non-overlap restarts the fill count but keeps shifting history.
      if (hit) fill_d = overlap ? FULL : '0;
      else     fill_d = next_fill;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match   = match_q;
  assign filled  = (fill_q == FULL);
  assign history = hist_q;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                   cnt_d = '0;
    else if (hit && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign match_count = cnt_q;
`endif

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial pattern detector for the DE2 lab designs. It shifts one qualified input bit per clock, compares the most recent LEN bits against a masked pattern, and emits a one-cycle match pulse. Overlapping or non-overlapping detection is selected at run time, and a saturating match counter is optional. It replaces hand-coded per-pattern FSMs: the board top wires a switch to `in_bit`, a debounced key to `clock`/`in_valid`, and `history`/`match_count` to the HEX/LED drivers.

## Interface

Parameters:
- `LEN`, 4: pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1100: target sequence, MSB = oldest bit.
- `MASK`, 4'b1110: per-bit compare enable; 0 = don't care. The default matches 1100 or 1101.
- `CNT_W`, 8: width of `match_count`.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low.
- `clear` in 1: synchronous clear, active-high.
- `in_valid` in 1: qualifies `in_bit` this cycle.
- `in_bit` in 1: serial data bit.
- `overlap` in 1: 1 = overlapping detection, 0 = non-overlapping.
- `match` out 1: registered one-cycle match pulse.
- `filled` out 1: at least LEN bits are held since reset, clear, or the last non-overlap restart.
- `history` out LEN: last LEN accepted bits, newest in bit 0.
- `match_count` out CNT_W: saturating count of match pulses. Present only with `SEQDET_COUNT_EN`.

## Operation

State:
- `history` register.
- Fill counter `fill`, 0..LEN, saturating at LEN.
- `match` register.
- Optional match counter.

Priority per edge: `reset` > `clear` > `in_valid` > hold.

- **Reset (async low):** `history`=0, `fill`=0, `match`=0, `match_count`=0, `filled`=0.
- **clear=1:** same values as reset, applied at the edge. `in_valid` is ignored that cycle.
- **in_valid=1:**
  - `next_hist = {history[LEN-2:0], in_bit}`.
  - `next_fill = min(fill+1, LEN)`.
  - `hit = (next_fill == LEN) && ((next_hist ^ PATTERN) & MASK) == 0`.
  - `history <= next_hist`, `match <= hit`.
  - If `hit` and `overlap`=1: `fill <= LEN`, so the next bit can complete another match.
  - If `hit` and `overlap`=0: `fill <= 0` and `history` still updates. A new match needs LEN further accepted bits.
  - If not `hit`: `fill <= next_fill`.
- **in_valid=0:** all state holds and `match <= 0`. `match` is never held for two cycles by a stalled input.
- **Output decode:** `filled = (fill == LEN)`, taken combinationally from the register.
- **Mode change:** `overlap` is sampled only on a hit edge. Changing it between bits is legal and takes effect at the next hit.
- **Illegal MASK = 0:** every bit is don't-care, so a match fires on every accepted bit once filled. This is documented, not flagged.

## Timing

- All outputs are registered or decoded from registers, with no combinational path from inputs to outputs.
- Latency: `match` is high in the cycle after the edge that accepted the final pattern bit, for exactly one cycle.
- Back-to-back: with overlap and a self-overlapping pattern, `match` can be high on consecutive cycles.
- Reset release: the first accepted bit is the edge after `reset` deasserts. Deassertion is assumed synchronised externally.
- Reset mid-sequence: partial progress is lost, and a full LEN bits are needed again.

## Configuration

- `SEQDET_COUNT_EN` defined:
  - `match_count` port and CNT_W-bit counter are built.
  - The counter increments on each edge where `hit`=1.
  - It saturates at 2^CNT_W−1, and is zeroed by `reset` or `clear`.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan

- **Default params, overlap=1:** feed 1,1,0,0 with `in_valid`=1 → `match`=1 only in the cycle after the 4th bit, `history`=4'b1100.
- **Don't-care bit:** feed 1,1,0,1 → `match` pulse. Then feed 1,0,0,0 → no pulse, since `history`=4'b1000 ≠ 110x.
- **Overlap vs non-overlap:** PATTERN=4'b1111, MASK=4'b1111, feed seven 1s.
  - overlap=1 → pulses after bits 4,5,6,7 (count 4).
  - overlap=0 → pulse after bit 4 only, then again only after bit 8 if a further 1 is fed.
- **Stall:** feed 1,1,0, hold `in_valid`=0 for 5 cycles, then feed 0 → single pulse one cycle after the final bit, `match`=0 throughout the stall.
- **Reset/clear mid-sequence:** feed 1,1,0, pulse `reset` low, then feed 0 → no match and `filled`=0. Repeat with `clear`=1 coincident with `in_valid` → the bit is dropped and `history`=0.
- **Counter saturation (`SEQDET_COUNT_EN`, CNT_W=2):** produce 5 matches → `match_count` reads 1,2,3,3,3. `clear` → 0.
